// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: formats stores, issues one bus request per
// access, formats load data, and stalls the pipeline while the access is out.
// Ports: pipeline side (MemReadM/MemWriteM/ALUResultM/WriteDataM/Funct3M ->
// ReadDataM/StallM/FaultM), bus side (req_* valid/ready request, rsp_* reply).
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [2:0]  Funct3M,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        FaultM,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_we,
  output logic [31:0] req_addr,
  output logic [3:0]  req_be,
  output logic [31:0] req_wdata,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d;
  logic        valid_q, valid_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        access;
  logic        is_wr;
  logic        bad;
  logic [1:0]  off;
  logic [3:0]  be_fmt;
  logic [31:0] wdata_fmt;
  logic [31:0] shifted;
  logic [31:0] load_fmt;

  assign access = MemReadM | MemWriteM;
  // Read+write together is a store.
  assign is_wr  = MemWriteM;
  assign off    = ALUResultM[1:0];

  always_comb begin
    bad = 1'b1;
    unique case (Funct3M)
      3'b000:  bad = 1'b0;
      3'b100:  bad = is_wr;
      3'b001:  bad = off[0];
      3'b101:  bad = off[0] | is_wr;
      3'b010:  bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    be_fmt    = 4'b1111;
    wdata_fmt = WriteDataM;
    unique case (Funct3M[1:0])
      2'b00: begin
        be_fmt    = 4'b0001 << off;
        wdata_fmt = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        be_fmt    = 4'b0011 << off;
        wdata_fmt = {2{WriteDataM[15:0]}};
      end
      default: begin
        be_fmt    = 4'b1111;
        wdata_fmt = WriteDataM;
      end
    endcase
  end

  assign shifted = rsp_rdata >> {off_q, 3'b000};

  always_comb begin
    load_fmt = shifted;
    unique case (f3_q)
      3'b000:  load_fmt = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_fmt = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_fmt = {24'h0, shifted[7:0]};
      3'b101:  load_fmt = {16'h0, shifted[15:0]};
      default: load_fmt = shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    f3_d    = f3_q;
    we_d    = we_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (access && !bad) begin
          state_d = REQ;
          off_d   = off;
          f3_d    = Funct3M;
          we_d    = is_wr;
          valid_d = 1'b1;
          addr_d  = {ALUResultM[31:2], 2'b00};
          be_d    = be_fmt;
          wdata_d = wdata_fmt;
        end
      end
      REQ: begin
        if (req_ready) begin
          state_d = RESP;
          valid_d = 1'b0;
        end
      end
      RESP: begin
        if (rsp_valid) begin
          state_d = DONE;
          if (!we_q) rdata_d = load_fmt;
        end
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      off_q   <= 2'b00;
      f3_q    <= 3'b000;
      we_q    <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // The accepting IDLE cycle already stalls, so the pipeline holds the access.
  assign StallM = !rst &&
                  ((state_q == REQ) || (state_q == RESP) ||
                   ((state_q == IDLE) && access && !bad));
  assign FaultM = !rst && (state_q == IDLE) && access && bad;

  assign ReadDataM = rdata_q;
  assign req_valid = valid_q;
  assign req_we    = we_q;
  assign req_addr  = addr_q;
  assign req_be    = be_q;
  assign req_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: acts as pipeline and bus slave,
// checking outputs with immediate assertions.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [2:0]  Funct3M;
  logic [31:0] ReadDataM;
  logic        StallM, FaultM;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;

  mem_access_unit dut (
    .clk        (clk),
    .rst        (rst),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .Funct3M    (Funct3M),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .FaultM     (FaultM),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_be     (req_be),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          n_stall, n_valid, n_fault;
  logic        done_ok, stable_ok, idle_bus_ok, done_stall, timed_out;
  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata, done_rdata;
  logic [3:0]  cap_be;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One access: pipeline inputs for one cycle, then a bus slave that raises
  // req_ready after rwait REQ cycles and rsp_valid after swait RESP cycles.
  task automatic run_access(input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [2:0] f3, input int rwait,
                            input int swait, input logic [31:0] rdata);
    int phase;
    int cnt;
    bit fin;
    bit first;
    n_stall = 0; n_valid = 0; n_fault = 0;
    done_ok = 0; stable_ok = 1; idle_bus_ok = 1; done_stall = 1;
    first = 1; phase = 0; cnt = 0; fin = 0;
    @(posedge clk); #1;
    MemReadM = rd; MemWriteM = wr; ALUResultM = addr;
    WriteDataM = wd; Funct3M = f3;
    for (int g = 0; g < 60 && !fin; g++) begin
      @(negedge clk);
      if (StallM) n_stall++;
      if (req_valid) n_valid++;
      if (FaultM) n_fault++;
      case (phase)
        0: begin
          if (req_valid) idle_bus_ok = 0;
          if (FaultM || !StallM) fin = 1;
          else phase = 1;
        end
        1: begin
          if (first) begin
            cap_we = req_we; cap_addr = req_addr;
            cap_be = req_be; cap_wdata = req_wdata;
            first = 0;
          end else if (req_we !== cap_we || req_addr !== cap_addr ||
                       req_be !== cap_be || req_wdata !== cap_wdata) begin
            stable_ok = 0;
          end
          if (!req_valid) stable_ok = 0;
          req_ready = (cnt >= rwait);
          cnt++;
          if (req_ready) begin phase = 2; cnt = 0; end
        end
        2: begin
          req_ready = 0;
          if (req_valid) idle_bus_ok = 0;
          rsp_rdata = rdata;
          rsp_valid = (cnt >= swait);
          cnt++;
          if (rsp_valid) phase = 3;
        end
        default: begin
          rsp_valid = 0;
          done_ok = 1;
          done_stall = StallM;
          done_rdata = ReadDataM;
          fin = 1;
        end
      endcase
      @(posedge clk); #1;
      MemReadM = 0; MemWriteM = 0;
    end
    timed_out = !fin;
    req_ready = 0; rsp_valid = 0;
  endtask

  task automatic chk_fault(input string tag);
    chk({tag, "_timeout"}, timed_out, 1'b0);
    chk({tag, "_fault"}, n_fault, 1);
    chk({tag, "_stall"}, n_stall, 0);
    @(negedge clk);
    chk({tag, "_fault_pulse"}, FaultM, 1'b0);
    chk({tag, "_no_req"}, {idle_bus_ok, req_valid}, 2'b10);
  endtask

  initial begin
    rst = 1; MemReadM = 1; MemWriteM = 0; ALUResultM = 32'h100;
    WriteDataM = 0; Funct3M = 3'b010; req_ready = 0; rsp_valid = 0;
    rsp_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", StallM, 1'b0);
    chk("rst_fault", FaultM, 1'b0);
    chk("rst_rdata", ReadDataM, 32'h0);
    chk("rst_req", {req_valid, req_we, req_be}, 6'h0);
    chk("rst_addr", req_addr, 32'h0);
    chk("rst_wdata", req_wdata, 32'h0);
    MemReadM = 0; rst = 0;

    run_access(1, 0, 32'h100, 0, 3'b010, 0, 0, 32'hDEADBEEF);
    chk("lw_done", {timed_out, done_ok}, 2'b01);
    chk("lw_stall", n_stall, 3);
    chk("lw_valid", n_valid, 1);
    chk("lw_addr", cap_addr, 32'h100);
    chk("lw_be_we", {cap_be, cap_we}, 5'b11110);
    chk("lw_rdata", done_rdata, 32'hDEADBEEF);
    chk("lw_done_stall", done_stall, 1'b0);
    chk("lw_bus_idle", idle_bus_ok, 1'b1);

    run_access(1, 0, 32'h103, 0, 3'b000, 0, 0, 32'h80123456);
    chk("lb_be", cap_be, 4'b1000);
    chk("lb_rdata", done_rdata, 32'hFFFFFF80);
    run_access(1, 0, 32'h103, 0, 3'b100, 0, 0, 32'h80123456);
    chk("lbu_rdata", done_rdata, 32'h00000080);

    run_access(0, 1, 32'h202, 32'h0000ABCD, 3'b001, 0, 0, 32'h5555AAAA);
    chk("sh_done", {timed_out, done_ok}, 2'b01);
    chk("sh_we", cap_we, 1'b1);
    chk("sh_addr", cap_addr, 32'h200);
    chk("sh_be", cap_be, 4'b1100);
    chk("sh_wdata", cap_wdata, 32'hABCDABCD);
    chk("sh_rdata_keep", done_rdata, 32'h00000080);

    run_access(1, 0, 32'h101, 0, 3'b010, 0, 0, 0);
    chk_fault("lw_mis");

    run_access(1, 0, 32'h102, 0, 3'b001, 0, 0, 32'h80017FFF);
    chk("lh_be", cap_be, 4'b1100);
    chk("lh_rdata", done_rdata, 32'hFFFF8001);
    run_access(1, 0, 32'h102, 0, 3'b101, 0, 0, 32'h80017FFF);
    chk("lhu_rdata", done_rdata, 32'h00008001);

    run_access(0, 1, 32'h201, 32'h123456A5, 3'b000, 0, 0, 0);
    chk("sb_addr", cap_addr, 32'h200);
    chk("sb_be", cap_be, 4'b0010);
    chk("sb_wdata", cap_wdata, 32'hA5A5A5A5);
    chk("sb_rdata_keep", done_rdata, 32'h00008001);

    run_access(1, 0, 32'h104, 0, 3'b010, 4, 2, 32'h01020304);
    chk("wait_done", {timed_out, done_ok}, 2'b01);
    chk("wait_valid", n_valid, 5);
    chk("wait_stable", stable_ok, 1'b1);
    chk("wait_stall", n_stall, 9);
    chk("wait_rdata", done_rdata, 32'h01020304);

    run_access(0, 1, 32'h300, 32'hFF, 3'b100, 0, 0, 0);
    chk_fault("sbu_ill");
    run_access(1, 0, 32'h300, 0, 3'b011, 0, 0, 0);
    chk_fault("f3_011");
    run_access(1, 0, 32'h301, 0, 3'b001, 0, 0, 0);
    chk_fault("lh_mis");
    chk("ill_rdata_keep", ReadDataM, 32'h01020304);

    run_access(1, 1, 32'h400, 32'h11223344, 3'b010, 0, 0, 32'h99999999);
    chk("rw_we", cap_we, 1'b1);
    chk("rw_be", cap_be, 4'b1111);
    chk("rw_wdata", cap_wdata, 32'h11223344);
    chk("rw_rdata_keep", done_rdata, 32'h01020304);

    @(posedge clk); #1;
    rsp_valid = 1; rsp_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    rsp_valid = 0;
    chk("idle_rsp_rdata", ReadDataM, 32'h01020304);
    chk("idle_rsp_stall", {StallM, req_valid}, 2'b00);

    MemReadM = 1; ALUResultM = 32'h100; Funct3M = 3'b010; req_ready = 1;
    @(posedge clk); #1;
    MemReadM = 0;
    @(posedge clk); #1;
    req_ready = 0;
    chk("mid_resp_stall", StallM, 1'b1);
    rst = 1;
    #1;
    chk("mid_rst_stall", StallM, 1'b0);
    @(posedge clk); #1;
    rst = 0; rsp_valid = 1; rsp_rdata = 32'h12345678;
    chk("mid_rst_state", {req_valid, StallM}, 2'b00);
    chk("mid_rst_rdata", ReadDataM, 32'h0);
    @(posedge clk); #1;
    rsp_valid = 0;
    chk("late_rsp_rdata", ReadDataM, 32'h0);
    chk("late_rsp_state", {req_valid, StallM, FaultM}, 3'b000);
    @(posedge clk); #1;
    chk("late_rsp_idle", {req_valid, StallM}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have the following ports (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- MemReadM  in  1  memory-stage load request
- MemWriteM  in  1  memory-stage store request
- ALUResultM  in  32  byte address
- WriteDataM  in  32  store data, right-justified
- Funct3M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ReadDataM  out  32  aligned, extended load result
- StallM  out  1  holds the pipeline while an access is in flight
- FaultM  out  1  misaligned or illegal access, 1-cycle pulse
- req_valid  out  1  bus request valid
- req_ready  in  1  bus accepts the request
- req_we  out  1  bus write enable
- req_addr  out  32  word address, bits [1:0] = 0
- req_be  out  4  byte enables
- req_wdata  out  32  lane-replicated store data
- rsp_valid  in  1  read data or write acknowledge valid
- rsp_rdata  in  32  bus read data

REQ-002 The block SHALL operate on one clock, clk, with synchronous active-high reset rst; it SHALL have no other clocks or asynchronous inputs.

Function
REQ-003 The FSM SHALL have four states: IDLE, REQ, RESP, DONE.
REQ-004 In IDLE, an access is MemReadM|MemWriteM. A legal access SHALL cause the following in the same cycle:
- StallM=1
- latch address, offset=ALUResultM[1:0], Funct3M, direction, and formatted store data
- transition to REQ
REQ-005 When MemReadM and MemWriteM are both high, the access SHALL be treated as a write.
REQ-006 An access is illegal in these cases:
- halfword with offset[0]=1
- word with offset≠0
- Funct3M in {011,110,111}
- store with Funct3M in {100,101}
REQ-007 For an illegal access, the block SHALL behave as follows:
- FaultM=1 for that cycle
- StallM=0
- no bus request
- remain in IDLE
- ReadDataM unchanged
REQ-008 In REQ, req_valid SHALL be 1 and req_we/req_addr/req_be/req_wdata SHALL be stable. The block SHALL stay in REQ until req_ready=1, then move to RESP. StallM=1.
REQ-009 In RESP, req_valid SHALL be 0 and StallM=1. On rsp_valid=1 the block SHALL move to DONE; for reads it SHALL register the formatted rsp_rdata into ReadDataM.
REQ-010 In DONE, StallM=0 and inputs SHALL be ignored; the next state SHALL be IDLE.
REQ-011 rsp_valid outside RESP SHALL be ignored.
REQ-012 Minimum stall SHALL be 3 cycles (IDLE, REQ, RESP with immediate ready and next-cycle rsp_valid). Wait states on req_ready or rsp_valid SHALL extend the stall 1:1 with no upper bound.
REQ-013 Store formatting SHALL be:
- byte: req_be=4'b0001<<offset, req_wdata={4{WriteDataM[7:0]}}
- half: req_be=4'b0011<<offset, req_wdata={2{WriteDataM[15:0]}}
- word: req_be=4'b1111, req_wdata=WriteDataM
REQ-014 For reads, req_be SHALL follow the same size rule and req_we SHALL be 0.
REQ-015 Load formatting SHALL shift rsp_rdata right by 8*offset, then extend as follows:
- B: sign-extend bit 7
- H: sign-extend bit 15
- BU/HU: zero-extend
- W: no extension
REQ-016 req_addr SHALL equal {address[31:2],2'b00}.
REQ-017 ReadDataM SHALL hold its last loaded value until the next completed read; stores SHALL NOT modify it.

Reset
REQ-018 On rst=1 at a clock edge, the block SHALL apply:
- state=IDLE
- ReadDataM=0
- FaultM=0
- req_valid=0, req_we=0, req_addr=0, req_be=0, req_wdata=0
REQ-019 StallM SHALL be 0 while rst is asserted, regardless of state or inputs.
REQ-020 Reset mid-transaction (REQ or RESP) SHALL abandon the access. A later rsp_valid SHALL be ignored while the block is in IDLE.

Verification
REQ-021 LW at 0x100, req_ready=1, rsp_valid next cycle with 0xDEADBEEF -> StallM high for 3 cycles, req_addr=0x100, req_be=1111, ReadDataM=0xDEADBEEF in DONE.
REQ-022 LB at 0x103, rsp_rdata=0x80123456 -> ReadDataM=0xFFFFFF80. LBU at the same address -> ReadDataM=0x00000080.
REQ-023 SH at 0x202, WriteDataM=0x0000ABCD -> req_we=1, req_addr=0x200, req_be=1100, req_wdata=0xABCDABCD; ReadDataM unchanged.
REQ-024 LW at 0x101 -> FaultM=1 for 1 cycle, StallM=0, req_valid never asserted.
REQ-025 req_ready held low for 4 cycles, then rsp_valid delayed 2 cycles -> req_valid held stable for 5 cycles, StallM high for 9 cycles total.
REQ-026 rst pulsed while in RESP, then rsp_valid=1 -> block in IDLE, req_valid=0, ReadDataM=0, StallM=0.
